// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-granular round-robin merge of NUM_PORTS FWFT FIFOs onto one output stage.
// Optional per-port completed-packet counters on pkt_cnt when MERGE_PKT_CNT_EN is defined.
module pkt_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int CNT_WIDTH = 16,
  localparam int GW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS*CTRL_WIDTH-1:0]  in_ctrl,
  input  logic [NUM_PORTS-1:0]             in_empty,
  output logic [NUM_PORTS-1:0]             in_rd_en,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy
`ifdef MERGE_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]   pkt_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
  state_t state;
  logic [GW-1:0] next_id;
  logic found;
  logic pop;
  logic last_pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  assign busy = state != IDLE;
  assign head_data = in_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign head_ctrl = in_ctrl[grant_id*CTRL_WIDTH +: CTRL_WIDTH];
  assign pop = busy & ~reset & out_rdy & ~in_empty[grant_id];
  assign last_pop = pop & (state == PAYLOAD) & (head_ctrl != '0);
  assign in_rd_en = pop ? NUM_PORTS'(1) << grant_id : '0;
  // descending scan so the port closest after grant_id is the last (winning) assignment
  always_comb begin
    next_id = grant_id;
    found = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (!in_empty[(int'(grant_id) + k) % NUM_PORTS]) begin
        found = 1'b1;
        next_id = GW'((int'(grant_id) + k) % NUM_PORTS);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= GW'(NUM_PORTS - 1);
      out_wr <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= pop;
      if (pop) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
      if (state == IDLE && found) begin
        grant_id <= next_id;
        state <= HDR;
      end else if (pop && state == HDR && head_ctrl == '0) begin
        state <= PAYLOAD;
      end else if (last_pop) begin
        state <= IDLE;
      end
    end
  end
`ifdef MERGE_PKT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt [NUM_PORTS];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else if (last_pop) begin
      cnt[grant_id] <= cnt[grant_id] + 1'b1;
    end
  end
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end
`endif
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb_pkt_rr_arbiter: packet-level reference model with FIFO queues, a directed vector table and random traffic.
module tb_pkt_rr_arbiter;
  localparam int N = 4, DW = 64, CW = 8, KW = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [N*DW-1:0] in_data;
  logic [N*CW-1:0] in_ctrl;
  logic [N-1:0] in_empty, in_rd_en;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic out_wr, out_rdy, busy;
  logic [1:0] grant_id;
`ifdef MERGE_PKT_CNT_EN
  logic [N*KW-1:0] pkt_cnt;
`endif
  always #5 clk = ~clk;

  pkt_rr_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(KW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .grant_id(grant_id), .busy(busy)
`ifdef MERGE_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  typedef struct {logic [3:0] rd; logic wr; logic bsy; logic [7:0] ctrl;} vec_t;
  vec_t tbl [8];
  logic [71:0] q [N][$];
  int lq [N][$];
  int ord [$];
  logic [N-1:0] mask;
  logic rdy;
  logic m_busy;
  int m_grant, m_rem;
  int m_cnt [N];
  logic e_wr;
  logic [63:0] e_d;
  logic [7:0] e_c;
  logic [3:0] last_rd;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int p, input int nh, input int np, input logic [7:0] hc, input logic [7:0] lc);
    logic [63:0] d;
    for (int h = 0; h < nh + np + 1; h++) begin
      d = {$urandom(), $urandom()};
      if (h < nh) q[p].push_back({hc != 0 ? hc : 8'($urandom_range(1, 255)), d});
      else if (h < nh + np) q[p].push_back({8'h00, d});
      else q[p].push_back({lc != 0 ? lc : 8'($urandom_range(1, 255)), d});
    end
    lq[p].push_back(nh + np + 1);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_empty[i] = (q[i].size() == 0) || mask[i];
      in_data[i*DW +: DW] = '0;
      in_ctrl[i*CW +: CW] = '0;
      if (!in_empty[i]) begin
        in_data[i*DW +: DW] = q[i][0][63:0];
        in_ctrl[i*CW +: CW] = q[i][0][71:64];
      end
    end
    out_rdy = rdy;
  endtask

  task automatic check_outs();
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_grant);
    chk("out_wr", out_wr, e_wr);
    chk("out_data", out_data, e_d);
    chk("out_ctrl", out_ctrl, e_c);
`ifdef MERGE_PKT_CNT_EN
    for (int i = 0; i < N; i++) chk("pkt_cnt", pkt_cnt[i*KW +: KW], m_cnt[i]);
`endif
  endtask

  // one clock: present FIFO heads, predict pops from packet-level rules, then check the registered outputs
  task automatic step();
    logic [N-1:0] erd;
    logic nb, f;
    int ng, idx;
    logic [71:0] w;
    drive();
    #1;
    erd = '0; nb = m_busy; ng = m_grant; f = 1'b0;
    if (!m_busy) begin
      for (int k = N; k >= 1; k--) begin
        idx = (m_grant + k) % N;
        if (!in_empty[idx]) begin ng = idx; f = 1'b1; end
      end
      if (f) begin nb = 1'b1; m_rem = lq[ng][0]; ord.push_back(ng); end
    end else if (!in_empty[m_grant] && rdy) begin
      erd[m_grant] = 1'b1;
    end
    last_rd = in_rd_en;
    chk("in_rd_en", in_rd_en, erd);
    e_wr = 1'b0;
    if (erd != 0) begin
      w = q[m_grant].pop_front();
      e_wr = 1'b1; e_d = w[63:0]; e_c = w[71:64];
      m_rem--;
      if (m_rem == 0) begin
        nb = 1'b0;
        void'(lq[m_grant].pop_front());
        m_cnt[m_grant] = (m_cnt[m_grant] + 1) % (1 << KW);
      end
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_grant = ng;
    check_outs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    #1;
    chk("rst_rd_en", in_rd_en, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin q[i].delete(); lq[i].delete(); m_cnt[i] = 0; end
    m_busy = 1'b0; m_grant = N - 1; e_wr = 1'b0; e_d = '0; e_c = '0; mask = '0;
    check_outs();
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    logic pend;
    mask = '0; rdy = 1'b1;
    do begin
      pend = m_busy;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) pend = 1'b1;
      if (pend && n < budget) begin step(); n++; end
    end while (pend && n < budget);
    if (pend) begin
      total++; bad++;
      $display("FAIL drain_timeout steps=%0d budget=%0d", n, budget);
    end
  endtask

  task automatic chk_order(input string nm, input int a, input int b);
    chk({nm, "_len"}, ord.size(), 2);
    if (ord.size() == 2) begin
      chk({nm, "_first"}, ord[0], a);
      chk({nm, "_second"}, ord[1], b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int wrc;
    tbl[0] = '{4'b0000, 1'b0, 1'b1, 8'h00};
    tbl[1] = '{4'b0001, 1'b1, 1'b1, 8'hFF};
    tbl[2] = '{4'b0001, 1'b1, 1'b1, 8'hFF};
    tbl[3] = '{4'b0001, 1'b1, 1'b1, 8'h00};
    tbl[4] = '{4'b0001, 1'b1, 1'b1, 8'h00};
    tbl[5] = '{4'b0001, 1'b1, 1'b1, 8'h00};
    tbl[6] = '{4'b0001, 1'b1, 1'b0, 8'h10};
    tbl[7] = '{4'b0000, 1'b0, 1'b0, 8'h10};
    rdy = 1'b1; mask = '0;
    @(negedge clk);
    do_reset();
    // single 6-word packet on port 0
    add_pkt(0, 2, 3, 8'hFF, 8'h10);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t1_rd", last_rd, tbl[c].rd);
      chk("t1_wr", out_wr, tbl[c].wr);
      chk("t1_busy", busy, tbl[c].bsy);
      chk("t1_ctrl", out_ctrl, tbl[c].ctrl);
    end
    chk("t1_grant", grant_id, 0);
    // all four ports pending from reset
    do_reset();
    for (int p = 0; p < N; p++) add_pkt(p, 1, 2, 8'h00, 8'h00);
    ord.delete();
    drain(200);
    chk("t2_len", ord.size(), 4);
    for (int i = 0; i < 4 && i < ord.size(); i++) chk("t2_order", ord[i], i);
    // wrap-around after port 3
    ord.delete();
    add_pkt(1, 2, 3, 8'h00, 8'h00);
    add_pkt(3, 1, 1, 8'h00, 8'h00);
    drain(200);
    chk_order("t3", 1, 3);
    // backpressure mid-payload
    add_pkt(0, 1, 6, 8'h00, 8'h00);
    repeat (4) step();
    rdy = 1'b0;
    wrc = 0;
    repeat (5) begin
      wrc += int'(out_wr);
      step();
    end
    chk("t4_wr_pulses", wrc, 1);
    chk("t4_busy", busy, 1);
    drain(200);
    // granted FIFO empty mid-payload while port 2 waits
    ord.delete();
    add_pkt(0, 1, 6, 8'h00, 8'h00);
    repeat (3) step();
    add_pkt(2, 1, 2, 8'h00, 8'h00);
    mask = 4'b0001;
    repeat (3) step();
    drain(200);
    chk_order("t5", 0, 2);
    // reset while in PAYLOAD
    add_pkt(1, 1, 4, 8'h00, 8'h00);
    repeat (4) step();
    chk("t6_busy_pre", busy, 1);
    do_reset();
`ifdef MERGE_PKT_CNT_EN
    repeat (5) add_pkt(0, 1, 1, 8'h00, 8'h00);
    drain(300);
    chk("t7_pkt_cnt0", pkt_cnt[KW-1:0], 1);
    do_reset();
`endif
    // random traffic, backpressure and FIFO underruns
    for (int s = 0; s < 1000; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        int p = $urandom_range(0, N - 1);
        if (lq[p].size() < 3) add_pkt(p, $urandom_range(1, 3), $urandom_range(1, 4), 8'h00, 8'h00);
      end
      rdy = $urandom_range(0, 3) != 0;
      mask = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'b0000;
      step();
    end
    drain(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
